morse_symbol_keyer: RTL and testbench

Serialises one latched Morse character into a keyed on/off line with standard Morse timing. It sits directly downstream of the D flip-flop input registers, which capture the operator's switch pattern and length. It also drives the transmitter output (LED/buzzer). It uses a start/ready handshake so the capture stage can hand over the next character only when the keyer is free.

---
 rtl/morse_pkg.sv | 24 ++
 rtl/morse_unit_timer.sv | 37 +++
 rtl/morse_symbol_keyer.sv | 142 ++++++++++++++
 tb/tb_morse_symbol_keyer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: state encoding, element/gap lengths in
// time units, and the default character length.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MARK       = 2'd1,
        SPACE      = 2'd2,
        LETTER_GAP = 2'd3
    } state_e;

    localparam int DEFAULT_MAX_LEN = 5;
    localparam int LEN_W           = 3;

    localparam logic [1:0] DOT_UNITS        = 2'd1;
    localparam logic [1:0] DASH_UNITS       = 2'd3;
    localparam logic [1:0] ELEM_GAP_UNITS   = 2'd1;
    localparam logic [1:0] LETTER_GAP_UNITS = 2'd3;

    function automatic logic [1:0] mark_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running Morse time-unit divider: counts 0..UNIT_CYCLES-1 and flags the
// terminal count; CLEAR restarts the unit so each phase begins on a boundary.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLEAR,
    output logic TICK
);

    localparam int                CNT_W    = $clog2(UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TERMINAL = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (CLEAR || (cnt_q == TERMINAL)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With UNIT_CYCLES=1 the counter is pinned at zero, so this fires every cycle.
    assign TICK = (cnt_q == TERMINAL);

endmodule

// File: rtl/morse_symbol_keyer.sv
// Morse keyer: latches one character (dot/dash pattern + length) on START and
// keys it out with 1/3-unit marks, 1-unit element gaps and a 3-unit letter gap.
module morse_symbol_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int MAX_LEN     = DEFAULT_MAX_LEN
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [MAX_LEN-1:0] PATTERN,
    input  logic [2:0]         LENGTH,
    output logic               READY,
    output logic               MORSE_OUT,
    output logic               DONE
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [1:0]         unit_q, unit_d;
    logic               ready_q, ready_d;
    logic               morse_q, morse_d;
    logic               done_q, done_d;

    logic               timer_clear;
    logic               tick;
    logic [1:0]         phase_units;
    logic               phase_done;
    logic               length_ok;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .CLK  (CLK),
        .RESET(RESET),
        .CLEAR(timer_clear),
        .TICK (tick)
    );

    always_comb begin
        case (state_q)
            MARK:    phase_units = mark_units(pattern_q[idx_q]);
            SPACE:   phase_units = ELEM_GAP_UNITS;
            default: phase_units = LETTER_GAP_UNITS;
        endcase
    end

    assign phase_done = tick && (unit_q == (phase_units - 2'd1));
    assign length_ok  = (LENGTH != '0) && (LENGTH <= MAX_LEN_V);

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        idx_d       = idx_q;
        unit_d      = unit_q;
        ready_d     = ready_q;
        morse_d     = morse_q;
        done_d      = 1'b0;
        timer_clear = 1'b0;

        // Outside IDLE, ticks that do not finish the phase just advance the unit count.
        if ((state_q != IDLE) && tick && !phase_done) begin
            unit_d = unit_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                unit_d      = '0;
                if (START && length_ok) begin
                    pattern_d = PATTERN;
                    len_d     = LENGTH;
                    idx_d     = '0;
                    state_d   = MARK;
                    morse_d   = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            MARK: begin
                if (phase_done) begin
                    timer_clear = 1'b1;
                    unit_d      = '0;
                    morse_d     = 1'b0;
                    state_d     = (idx_q == (len_q - 3'd1)) ? LETTER_GAP : SPACE;
                end
            end
            SPACE: begin
                if (phase_done) begin
                    timer_clear = 1'b1;
                    unit_d      = '0;
                    idx_d       = idx_q + 3'd1;
                    morse_d     = 1'b1;
                    state_d     = MARK;
                end
            end
            LETTER_GAP: begin
                if (phase_done) begin
                    timer_clear = 1'b1;
                    unit_d      = '0;
                    ready_d     = 1'b1;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The latched character is pure data and is only consumed after a legal START.
    always_ff @(posedge CLK) begin
        pattern_q <= pattern_d;
        len_q     <= len_d;
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            unit_q  <= '0;
            ready_q <= 1'b1;
            morse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            unit_q  <= unit_d;
            ready_q <= ready_d;
            morse_q <= morse_d;
            done_q  <= done_d;
        end
    end

    assign READY     = ready_q;
    assign MORSE_OUT = morse_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_morse_symbol_keyer.sv
// Bench for morse_symbol_keyer: a UNIT_CYCLES=4 instance and a UNIT_CYCLES=1
// instance checked cycle by cycle against a queue-based timing model.
module tb_morse_symbol_keyer;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] pattern;
    logic [2:0] length;
    logic       sel1;

    logic start0, start1;
    logic ready0, morse0, done0;
    logic ready1, morse1, done1;
    logic ready_o, morse_o, done_o;

    int checks = 0;
    int errors = 0;
    int cur_u  = U;
    bit exp_q[$];

    always #5 clk = ~clk;

    assign start0  = start && !sel1;
    assign start1  = start && sel1;
    assign ready_o = sel1 ? ready1 : ready0;
    assign morse_o = sel1 ? morse1 : morse0;
    assign done_o  = sel1 ? done1  : done0;

    morse_symbol_keyer #(.UNIT_CYCLES(U), .MAX_LEN(5)) dut (
        .CLK(clk), .RESET(rst), .START(start0), .PATTERN(pattern), .LENGTH(length),
        .READY(ready0), .MORSE_OUT(morse0), .DONE(done0)
    );

    morse_symbol_keyer #(.UNIT_CYCLES(1), .MAX_LEN(5)) dut_u1 (
        .CLK(clk), .RESET(rst), .START(start1), .PATTERN(pattern), .LENGTH(length),
        .READY(ready1), .MORSE_OUT(morse1), .DONE(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for every cycle after the START edge, up to the last gap cycle.
    task automatic model_wave(input logic [4:0] pat, input logic [2:0] len, input int u);
        exp_q.delete();
        for (int e = 0; e < int'(len); e++) begin
            repeat ((pat[e] ? 3 : 1) * u) exp_q.push_back(1'b1);
            if (e < int'(len) - 1) repeat (u) exp_q.push_back(1'b0);
        end
        repeat (3 * u) exp_q.push_back(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // START is driven in the current cycle (cycle 0); checks cycles 1..n+1 and one more.
    task automatic run_char(input logic [4:0] pat, input logic [2:0] len, input bit disturb,
                            output int done_cyc);
        int n;
        bit em, er, ed;
        model_wave(pat, len, cur_u);
        n = exp_q.size();
        pattern = pat; length = len; start = 1'b1;
        done_cyc = -1;
        for (int c = 1; c <= n + 1; c++) begin
            step();
            start   = 1'b0;
            pattern = 5'($urandom);
            length  = 3'($urandom);
            if (disturb && (c == 5 || c == 10)) start = 1'b1;
            em = (c <= n) ? exp_q[c-1] : 1'b0;
            er = (c > n);
            ed = (c > n);
            checks++;
            if (morse_o !== em) begin
                errors++; $display("FAIL morse_out cycle %0d pat %b len %0d: got %b expected %b", c, pat, len, morse_o, em);
            end
            checks++;
            if (ready_o !== er) begin
                errors++; $display("FAIL ready cycle %0d pat %b len %0d: got %b expected %b", c, pat, len, ready_o, er);
            end
            checks++;
            if (done_o !== ed) begin
                errors++; $display("FAIL done cycle %0d pat %b len %0d: got %b expected %b", c, pat, len, done_o, ed);
            end
            if (done_o === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        step();
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL after_done: got done %b ready %b expected done 0 ready 1", done_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pattern = 5'b00010; length = 3'd2;
        step();
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++;
        if (morse_o !== 1'b0) begin errors++; $display("FAIL reset_morse: got %b expected 0", morse_o); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({ready_o, morse_o, done_o} !== 3'b100) begin
            errors++; $display("FAIL reset_idle: got rdy/mo/dn %b expected 100", {ready_o, morse_o, done_o});
        end
    endtask

    task automatic test_letters();
        int d;
        do_reset();
        run_char(5'b00010, 3'd2, 1'b0, d);
        checks++;
        if (d !== 33) begin errors++; $display("FAIL done_cycle_A: got %0d expected 33", d); end
        run_char(5'b00000, 3'd1, 1'b0, d);
        checks++;
        if (d !== 17) begin errors++; $display("FAIL done_cycle_E: got %0d expected 17", d); end
        run_char(5'b00001, 3'd1, 1'b0, d);
        checks++;
        if (d !== 25) begin errors++; $display("FAIL done_cycle_T: got %0d expected 25", d); end
    endtask

    task automatic test_start_while_busy();
        int d;
        do_reset();
        run_char(5'b00010, 3'd2, 1'b1, d);
        checks++;
        if (d !== 33) begin errors++; $display("FAIL busy_done_cycle: got %0d expected 33", d); end
    endtask

    task automatic test_illegal_length();
        logic [2:0] bad [3] = '{3'd0, 3'd6, 3'd7};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            length = bad[k]; pattern = 5'($urandom); start = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                step();
                checks++;
                if ({ready_o, morse_o, done_o} !== 3'b100) begin
                    errors++;
                    $display("FAIL illegal_len %0d cycle %0d: got rdy/mo/dn %b expected 100", bad[k], c, {ready_o, morse_o, done_o});
                end
            end
            start = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid_char();
        int d;
        do_reset();
        model_wave(5'b00010, 3'd2, cur_u);
        pattern = 5'b00010; length = 3'd2; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            checks++;
            if (morse_o !== exp_q[c-1] || ready_o !== 1'b0) begin
                errors++; $display("FAIL pre_reset cycle %0d: got mo %b rdy %b expected mo %b rdy 0", c, morse_o, ready_o, exp_q[c-1]);
            end
            if (c == 10) rst = 1'b1;
        end
        step();
        rst = 1'b0;
        for (int c = 11; c <= 12; c++) begin
            checks++;
            if ({ready_o, morse_o, done_o} !== 3'b100) begin
                errors++; $display("FAIL post_reset cycle %0d: got rdy/mo/dn %b expected 100", c, {ready_o, morse_o, done_o});
            end
            if (c == 11) step();
        end
        run_char(5'b00000, 3'd1, 1'b0, d);
        checks++;
        if (d !== 17) begin errors++; $display("FAIL restart_done: got %0d expected 17", d); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit em, er, ed;
        do_reset();
        model_wave(5'b00000, 3'd1, cur_u);
        n = exp_q.size();
        pattern = 5'b00000; length = 3'd1; start = 1'b1;
        for (int c = 1; c <= 2 * (n + 1); c++) begin
            step();
            if (c == 2 * (n + 1)) start = 1'b0;
            em = (c % (n + 1) == 0) ? 1'b0 : exp_q[(c % (n + 1)) - 1];
            er = (c % (n + 1) == 0);
            ed = er;
            checks++;
            if ({ready_o, morse_o, done_o} !== {er, em, ed}) begin
                errors++; $display("FAIL back_to_back cycle %0d: got rdy/mo/dn %b expected %b", c, {ready_o, morse_o, done_o}, {er, em, ed});
            end
        end
        step();
        checks++;
        if ({ready_o, morse_o, done_o} !== 3'b100) begin
            errors++; $display("FAIL back_to_back_end: got rdy/mo/dn %b expected 100", {ready_o, morse_o, done_o});
        end
    endtask

    task automatic test_random();
        int d;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_char(5'($urandom), 3'($urandom_range(1, 5)), 1'($urandom), d);
        end
    endtask

    task automatic test_unit_one();
        int d;
        sel1 = 1'b1; cur_u = 1;
        do_reset();
        run_char(5'b00010, 3'd2, 1'b0, d);
        checks++;
        if (d !== 9) begin errors++; $display("FAIL u1_done_A: got %0d expected 9", d); end
        for (int i = 0; i < 8; i++) begin
            run_char(5'($urandom), 3'($urandom_range(1, 5)), 1'b0, d);
        end
        sel1 = 1'b0; cur_u = U;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; length = '0; sel1 = 1'b0;
        step();
        test_reset();
        test_letters();
        test_start_while_busy();
        test_illegal_length();
        test_reset_mid_char();
        test_back_to_back();
        test_random();
        test_unit_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
